// File: rtl/conv_frame_sched.sv
// Frame scheduler for the 3x3 Gaussian convolution path.
// Walks every valid 3x3 window of a W x H image (no padding) in raster order.
// Each window goes out as a request to the fetch stage. A credit counter caps
// the number of windows in flight. Returned conv results are counted, and the
// frame completes once the last window's result has come back.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; conv_valid ignored
// S_ISSUE | issuing window requests while credits are available
// S_DRAIN | all windows issued, waiting for outstanding results
// S_DONE  | one-cycle completion pulse, then back to idle
module conv_frame_sched #(
  parameter int DIM_W   = 11,
  parameter int MAX_OUT = 4,
  parameter int CNT_W   = 22
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [DIM_W-1:0] i_cfg_width,
  input  logic [DIM_W-1:0] i_cfg_height,
  output logic             o_win_req_valid,
  input  logic             i_win_req_ready,
  output logic [DIM_W-1:0] o_win_x,
  output logic [DIM_W-1:0] o_win_y,
  output logic             o_win_last,
  input  logic             i_conv_valid,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_cfg_err,
  output logic             o_protocol_err,
  output logic [CNT_W-1:0] o_out_count
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t           r_state;
  logic [DIM_W-1:0] r_w;
  logic [DIM_W-1:0] r_h;
  logic [DIM_W-1:0] r_x;
  logic [DIM_W-1:0] r_y;
  logic [3:0]       r_outstanding;
  logic [CNT_W-1:0] r_out_count;
  logic             r_busy;
  logic             r_done;
  logic             r_cfg_err;
  logic             r_protocol_err;

  logic w_valid;
  logic w_hs;
  logic w_x_end;
  logic w_last;
  logic w_active;
  logic w_cv_ok;
  logic w_cv_bad;
  logic w_cfg_ok;

  // Valid depends only on registered credit state, so a freed credit takes
  // effect one cycle after the conv_valid that freed it.
  assign w_valid  = (r_state == S_ISSUE) && (r_outstanding < 4'(MAX_OUT));
  assign w_hs     = w_valid && i_win_req_ready;
  assign w_x_end  = (r_x == r_w - DIM_W'(3));
  assign w_last   = w_x_end && (r_y == r_h - DIM_W'(3));
  assign w_active = (r_state != S_IDLE);
  assign w_cv_ok  = i_conv_valid && w_active && (r_outstanding != 4'd0);
  assign w_cv_bad = i_conv_valid && w_active && (r_outstanding == 4'd0);
  assign w_cfg_ok = (i_cfg_width >= DIM_W'(3)) && (i_cfg_height >= DIM_W'(3));

  assign o_win_req_valid = w_valid;
  assign o_win_x         = r_x;
  assign o_win_y         = r_y;
  assign o_win_last      = (r_state == S_ISSUE) && w_last;
  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_cfg_err       = r_cfg_err;
  assign o_protocol_err  = r_protocol_err;
  assign o_out_count     = r_out_count;

  // Frame FSM, window coordinates, credit counter and result counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= S_IDLE;
      r_w            <= '0;
      r_h            <= '0;
      r_x            <= '0;
      r_y            <= '0;
      r_outstanding  <= '0;
      r_out_count    <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_cfg_err      <= 1'b0;
      r_protocol_err <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;

      if (w_cv_bad) r_protocol_err <= 1'b1;
      if (w_cv_ok)  r_out_count    <= r_out_count + CNT_W'(1);

      case ({w_hs, w_cv_ok})
        2'b10:   r_outstanding <= r_outstanding + 4'd1;
        2'b01:   r_outstanding <= r_outstanding - 4'd1;
        default: r_outstanding <= r_outstanding;
      endcase

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if (w_cfg_ok) begin
              r_w            <= i_cfg_width;
              r_h            <= i_cfg_height;
              r_x            <= '0;
              r_y            <= '0;
              r_outstanding  <= '0;
              r_out_count    <= '0;
              r_protocol_err <= 1'b0;
              r_busy         <= 1'b1;
              r_state        <= S_ISSUE;
            end else begin
              r_cfg_err <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (w_hs) begin
            if (w_x_end) begin
              r_x <= '0;
              r_y <= r_y + DIM_W'(1);
            end else begin
              r_x <= r_x + DIM_W'(1);
            end
            if (w_last) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (r_outstanding == 4'd0) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_frame_sched.sv
// Scoreboard bench for conv_frame_sched: expected window requests are queued
// by the stimulus and popped by a negedge monitor on every handshake.
module tb_conv_frame_sched;

  localparam int DIM_W   = 11;
  localparam int MAX_OUT = 4;
  localparam int CNT_W   = 22;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [DIM_W-1:0] cfg_w = '0;
  logic [DIM_W-1:0] cfg_h = '0;
  logic             req_valid;
  logic             req_ready = 1'b0;
  logic [DIM_W-1:0] win_x;
  logic [DIM_W-1:0] win_y;
  logic             win_last;
  logic             conv_valid;
  logic             busy;
  logic             done;
  logic             cfg_err;
  logic             perr;
  logic [CNT_W-1:0] out_count;

  logic cv_man  = 1'b0;
  logic cv_auto = 1'b0;
  logic auto_ret = 1'b0;
  logic [2:0] ret_pipe = 3'b000;

  int n_tests = 0;
  int n_fail  = 0;
  int hs_count = 0;
  int done_count = 0;

  typedef struct packed {
    logic [DIM_W-1:0] x;
    logic [DIM_W-1:0] y;
    logic             last;
  } win_t;

  win_t exp_q[$];

  assign conv_valid = cv_man | cv_auto;

  always #5 clk = ~clk;

  conv_frame_sched #(
    .DIM_W  (DIM_W),
    .MAX_OUT(MAX_OUT),
    .CNT_W  (CNT_W)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_start        (start),
    .i_cfg_width    (cfg_w),
    .i_cfg_height   (cfg_h),
    .o_win_req_valid(req_valid),
    .i_win_req_ready(req_ready),
    .o_win_x        (win_x),
    .o_win_y        (win_y),
    .o_win_last     (win_last),
    .i_conv_valid   (conv_valid),
    .o_busy         (busy),
    .o_done         (done),
    .o_cfg_err      (cfg_err),
    .o_protocol_err (perr),
    .o_out_count    (out_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: scoreboard pop on handshake, done counting, and the conv return
  // model (result arrives two cycles after each handshake when enabled).
  always @(negedge clk) begin
    logic hs;
    win_t e;
    hs = req_valid && req_ready;
    if (hs) begin
      hs_count++;
      if (exp_q.size() == 0) begin
        chk("unexpected_req", 32'(win_x), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("win_x", 32'(win_x), 32'(e.x));
        chk("win_y", 32'(win_y), 32'(e.y));
        chk("win_last", 32'(win_last), 32'(e.last));
      end
    end
    if (done) done_count++;
    ret_pipe = {ret_pipe[1:0], hs};
    cv_auto  = auto_ret && ret_pipe[2];
  end

  task automatic push(input int x, input int y, input logic last);
    win_t e;
    e.x = DIM_W'(x);
    e.y = DIM_W'(y);
    e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int w, input int h);
    @(posedge clk); #1;
    start = 1'b1;
    cfg_w = DIM_W'(w);
    cfg_h = DIM_W'(h);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pulse_cv(input int n);
    @(posedge clk); #1;
    cv_man = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    cv_man = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  initial begin
    int d0;

    // Reset state
    cycles(3);
    chk("rst_valid", 32'(req_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_count", 32'(out_count), 0);
    chk("rst_perr", 32'(perr), 0);
    rst = 1'b0;
    cycles(1);

    // W=5, H=4 with automatic returns, plus a start pulsed mid-frame
    push(0, 0, 0); push(1, 0, 0); push(2, 0, 0);
    push(0, 1, 0); push(1, 1, 0); push(2, 1, 1);
    auto_ret  = 1'b1;
    req_ready = 1'b1;
    d0 = done_count;
    pulse_start(5, 4);
    chk("b_busy_after_start", 32'(busy), 1);
    pulse_start(3, 3);
    chk("b_busy_mid", 32'(busy), 1);
    wait_done("b_done", 200);
    chk("b_done_busy", 32'(busy), 0);
    cycles(4);
    chk("b_done_once", 32'(done_count - d0), 1);
    chk("b_count", 32'(out_count), 6);
    chk("b_perr", 32'(perr), 0);
    chk("b_q_empty", 32'(exp_q.size()), 0);

    // W=3, H=3: one window, last
    push(0, 0, 1);
    pulse_start(3, 3);
    wait_done("c_done", 100);
    cycles(2);
    chk("c_count", 32'(out_count), 1);
    chk("c_q_empty", 32'(exp_q.size()), 0);

    // W=2, H=8: rejected
    pulse_start(2, 8);
    chk("e_cfg_err", 32'(cfg_err), 1);
    chk("e_busy", 32'(busy), 0);
    cycles(1);
    chk("e_cfg_err_pulse", 32'(cfg_err), 0);
    chk("e_busy2", 32'(busy), 0);
    chk("e_valid", 32'(req_valid), 0);

    // Credit stall: W=H=10, no returns
    auto_ret = 1'b0;
    cycles(4);
    push(0, 0, 0); push(1, 0, 0); push(2, 0, 0); push(3, 0, 0);
    d0 = hs_count;
    pulse_start(10, 10);
    cycles(10);
    chk("f_hs4", 32'(hs_count - d0), 4);
    chk("f_stall_valid", 32'(req_valid), 0);

    // One credit back under backpressure: (4,0) held stable for 5 cycles
    req_ready = 1'b0;
    push(4, 0, 0);
    pulse_cv(1);
    chk("f_revalid", 32'(req_valid), 1);
    chk("f_x", 32'(win_x), 4);
    chk("f_y", 32'(win_y), 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(req_valid), 1);
      chk("bp_x", 32'(win_x), 4);
      chk("bp_y", 32'(win_y), 0);
      chk("bp_last", 32'(win_last), 0);
    end
    @(posedge clk); #1;
    req_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_hs5", 32'(hs_count - d0), 5);
    chk("bp_valid_after", 32'(req_valid), 0);
    chk("bp_q_empty", 32'(exp_q.size()), 0);

    // Drain all credits with ready low, then a stray conv_valid
    req_ready = 1'b0;
    pulse_cv(4);
    chk("g_count", 32'(out_count), 5);
    chk("g_perr0", 32'(perr), 0);
    chk("g_valid", 32'(req_valid), 1);
    chk("g_x", 32'(win_x), 5);
    pulse_cv(1);
    chk("g_perr1", 32'(perr), 1);
    chk("g_count_hold", 32'(out_count), 5);
    cycles(2);
    chk("g_perr_sticky", 32'(perr), 1);

    // Reset mid-ISSUE
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("h_valid", 32'(req_valid), 0);
    chk("h_x", 32'(win_x), 0);
    chk("h_y", 32'(win_y), 0);
    chk("h_last", 32'(win_last), 0);
    chk("h_busy", 32'(busy), 0);
    chk("h_perr", 32'(perr), 0);
    chk("h_count", 32'(out_count), 0);
    rst = 1'b0;
    pulse_cv(1);
    cycles(1);
    chk("h_idle_cv_perr", 32'(perr), 0);
    chk("h_idle_cv_count", 32'(out_count), 0);

    // Clean frame after reset: W=4, H=4
    push(0, 0, 0); push(1, 0, 0); push(0, 1, 0); push(1, 1, 1);
    auto_ret  = 1'b1;
    req_ready = 1'b1;
    d0 = done_count;
    pulse_start(4, 4);
    wait_done("i_done", 200);
    cycles(3);
    chk("i_done_once", 32'(done_count - d0), 1);
    chk("i_count", 32'(out_count), 4);
    chk("i_perr", 32'(perr), 0);
    chk("i_q_empty", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/conv_frame_sched.md
Name: conv_frame_sched

Overview:
- Frame-level scheduler for the 3x3 Gaussian convolution datapath.
- On a start command it walks every valid 3x3 window position of a W x H image in raster order. There is no padding, so the output is (W-2) x (H-2).
- Each window is issued as a request to the window-fetch/line-buffer stage that feeds conv.
- It limits in-flight windows with a credit counter, counts conv_valid results, and signals frame completion.

Parameters:
- DIM_W, 11, width of the image dimension and coordinate fields (max 2047).
- MAX_OUT, 4, maximum windows issued but not yet returned as conv_valid (1..15).
- CNT_W, 22, width of out_count; must be >= 2*DIM_W.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  frame start pulse; sampled only in IDLE
- cfg_width  in  DIM_W  image width W in pixels
- cfg_height  in  DIM_W  image height H in pixels
- win_req_valid  out  1  window request valid
- win_req_ready  in  1  fetch stage accepts request
- win_x  out  DIM_W  top-left column of requested window
- win_y  out  DIM_W  top-left row of requested window
- win_last  out  1  current request is the final window of the frame
- conv_valid  in  1  one convolved pixel returned (driven by conv)
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when the frame completes
- cfg_err  out  1  one-cycle pulse when start is rejected for bad config
- protocol_err  out  1  sticky; cleared by the next accepted start
- out_count  out  CNT_W  conv_valid count in the current frame

Behaviour:
- Reset is synchronous: rst high at a rising edge puts every output to 0, the state to IDLE, and all counters to 0.
- rst mid-frame aborts immediately. No done pulse. In-flight conv_valid arriving after reset is ignored; protocol_err is not set in IDLE.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 with cfg_width>=3 and cfg_height>=3: latch W and H, set x=0, y=0, outstanding=0, out_count=0, clear protocol_err, go to ISSUE. busy goes to 1 on the next cycle.
  - start=1 with W<3 or H<3: cfg_err pulses one cycle, stay in IDLE.
- start is ignored outside IDLE.
- ISSUE:
  - win_req_valid = (outstanding < MAX_OUT). win_x/win_y show the current x/y; win_last = (x==W-3 && y==H-3).
  - Once asserted, valid and the payload stay stable until handshake. This holds because outstanding cannot rise without a handshake.
  - Handshake is win_req_valid && win_req_ready. On handshake:
    - If x==W-3: x becomes 0 and y increments; otherwise x increments.
    - If win_last: go to DRAIN and deassert valid the next cycle.
- Outstanding counter:
  - +1 on handshake, -1 on conv_valid. Both in the same cycle leaves it unchanged.
  - The credit freed by conv_valid enables valid on the following cycle, not combinationally.
- conv_valid with outstanding==0 in any state other than IDLE: set protocol_err, do not decrement, do not count.
- out_count increments on every accepted conv_valid. It holds its value after done until the next start.
- DRAIN: valid=0; when outstanding==0, go to DONE.
- DONE: done=1 for exactly one cycle, busy=0 from this cycle, go to IDLE.
- Totals per frame: exactly (W-2)*(H-2) handshakes and the same number of accepted conv_valid. The window order is raster with x fastest.

Test Plan:
- W=5, H=4, ready=1, conv_valid returned 2 cycles after each handshake:
  - requests (0,0),(1,0),(2,0),(0,1),(1,1),(2,1);
  - win_last only on (2,1);
  - done pulses once after the 6th conv_valid;
  - out_count=6, protocol_err=0.
- Credit stall (MAX_OUT=4, W=H=10, ready=1, no conv_valid):
  - exactly 4 handshakes, then valid=0;
  - one conv_valid re-asserts valid the next cycle with (4,0).
- Backpressure (ready held 0 for 5 cycles while valid=1): win_x/win_y/win_last are stable throughout, and the handshake completes on the first ready=1 cycle.
- Boundary configs:
  - W=3, H=3: single request (0,0) with win_last=1, done after 1 conv_valid.
  - W=2, H=8: cfg_err pulses, busy stays 0.
- Protocol and control:
  - conv_valid with outstanding==0 during ISSUE sets protocol_err and leaves out_count unchanged.
  - A start pulsed mid-frame is ignored.
  - rst asserted mid-ISSUE: next cycle all outputs are 0, the state is IDLE, and a new start runs a clean frame.
